// File: rtl/control_sequencer.sv
// Hard-wired control unit: fetch (T0-T2) plus per-opcode execute steps (T3-T7),
// with control outputs decoded combinationally from the present state and IR.
module control_sequencer (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        MDRout,
  output logic        In_Portout,
  output logic        Cout,
  output logic        Rout,
  output logic        Baout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        PCin,
  output logic        HIin,
  output logic        LOin,
  output logic        r_in,
  output logic        CONin,
  output logic        outPortenable,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  operation,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
  } state_t;

  typedef enum logic [4:0] {
    OP_LDW, OP_LDWI, OP_STW, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
    OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV, OP_NEG, OP_NOT,
    OP_BRANCH, OP_JR, OP_JAL, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT
  } opcode_t;

  state_t  state, next_state;
  opcode_t opc;
  logic    last;

  assign opc = opcode_t'(IR[31:27]);

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state <= S_RESET;
    else        state <= next_state;
  end

  always_comb begin
    {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, In_Portout, Cout, Rout, Baout} = '0;
    {MARin, MDRin, IRin, Yin, Zin, PCin, HIin, LOin, r_in, CONin, outPortenable} = '0;
    {Gra, Grb, Grc, IncPC, Read, Write} = '0;
    operation  = OP_ADD;
    Run        = 1'b1;
    last       = 1'b0;
    next_state = state;

    case (state)
      S_RESET: begin
        operation  = '0;
        next_state = S_T0;
      end
      S_HALTED: begin
        operation = '0;
        Run       = 1'b0;
      end
      S_T0: begin
        {PCout, MARin, IncPC, Zin} = '1;
        next_state = S_T1;
      end
      S_T1: begin
        {Zlowout, PCin, Read, MDRin} = '1;
        next_state = S_T2;
      end
      S_T2: begin
        {MDRout, IRin} = '1;
        // nop, halt and every opcode past mflo have no execute steps
        if (IR[31:27] == OP_HALT)     next_state = S_HALTED;
        else if (IR[31:27] > OP_MFLO) next_state = S_T0;
        else                          next_state = S_T3;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        // Opcode is re-decoded every step; a step with no listed action ends the instruction
        case (opc)
          OP_LDW, OP_LDWI, OP_STW: begin
            case (state)
              S_T3: {Grb, Baout, Yin} = '1;
              S_T4: {Cout, Zin} = '1;
              S_T5: begin
                Zlowout = 1'b1;
                if (opc == OP_LDWI) begin
                  {Gra, r_in} = '1;
                  last = 1'b1;
                end else begin
                  MARin = 1'b1;
                end
              end
              S_T6: begin
                if (opc == OP_LDW)      {Read, MDRin} = '1;
                else if (opc == OP_STW) {Gra, Rout, MDRin} = '1;
                else                    last = 1'b1;
              end
              default: begin
                if (state == S_T7 && opc == OP_LDW)      {MDRout, Gra, r_in} = '1;
                else if (state == S_T7 && opc == OP_STW) Write = 1'b1;
                last = 1'b1;
              end
            endcase
          end
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (state)
              S_T3: {Grb, Rout, Yin} = '1;
              S_T4: begin
                Zin       = 1'b1;
                operation = IR[31:27];
                if (opc inside {OP_ADDI, OP_ANDI, OP_ORI}) Cout = 1'b1;
                else                                       {Grc, Rout} = '1;
              end
              S_T5: begin
                {Zlowout, Gra, r_in} = '1;
                last = 1'b1;
              end
              default: last = 1'b1;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (state)
              S_T3: {Gra, Rout, Yin} = '1;
              S_T4: begin
                {Grb, Rout, Zin} = '1;
                operation = IR[31:27];
              end
              S_T5: {Zlowout, LOin} = '1;
              S_T6: begin
                {Zhighout, HIin} = '1;
                last = 1'b1;
              end
              default: last = 1'b1;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (state)
              S_T3: begin
                {Grb, Rout, Zin} = '1;
                operation = IR[31:27];
              end
              S_T4: begin
                {Zlowout, Gra, r_in} = '1;
                last = 1'b1;
              end
              default: last = 1'b1;
            endcase
          end
          OP_BRANCH: begin
            case (state)
              S_T3: {Gra, Rout, CONin} = '1;
              S_T4: {PCout, Yin} = '1;
              S_T5: {Cout, Zin} = '1;
              S_T6: begin
                Zlowout = 1'b1;
                PCin    = CON_FF;
                last    = 1'b1;
              end
              default: last = 1'b1;
            endcase
          end
          OP_JAL: begin
            case (state)
              S_T3: {PCout, Grb, r_in} = '1;
              S_T4: begin
                {Gra, Rout, PCin} = '1;
                last = 1'b1;
              end
              default: last = 1'b1;
            endcase
          end
          OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: begin
            if (state == S_T3) begin
              Gra = 1'b1;
              case (opc)
                OP_JR:   {Rout, PCin} = '1;
                OP_IN:   {In_Portout, r_in} = '1;
                OP_OUT:  {Rout, outPortenable} = '1;
                OP_MFHI: {HIout, r_in} = '1;
                default: {LOout, r_in} = '1;
              endcase
            end
            last = 1'b1;
          end
          default: last = 1'b1;
        endcase

        if (last) next_state = S_T0;
        else begin
          case (state)
            S_T3:    next_state = S_T4;
            S_T4:    next_state = S_T5;
            S_T5:    next_state = S_T6;
            S_T6:    next_state = S_T7;
            default: next_state = S_T0;
          endcase
        end
      end
      default: next_state = S_RESET;
    endcase
  end

endmodule
